// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (read-only)
// and load/store (read/write). One transaction in flight at a time, round-robin
// on ties, registered memory-side payload, response routed back to its owner,
// and a watchdog that forces a response if memory never answers.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  // load/store requester
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [AW-1:0]     ls_addr,
  input  logic [DW-1:0]     ls_wdata,
  input  logic [DW/8-1:0]   ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DW-1:0]     ls_rdata,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  // sticky protocol / timeout error
  output logic              err
);

  localparam int WMW = DW / 8;
  // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT     = CW'(TIMEOUT);
  localparam logic          WD_EN        = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic             last_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [WMW-1:0]   mem_wmask_q;

  logic             win_if_s;
  logic             win_ls_s;
  logic             rsp_real_s;
  logic             rsp_to_s;
  logic             rsp_valid_s;
  logic [DW-1:0]    rsp_data_s;
  logic             err_set_s;

  // Round-robin winner selection: on a tie the requester that did not own the
  // previous transaction wins; only meaningful (and only granted) in IDLE.
  always_comb begin
    win_if_s = 1'b0;
    win_ls_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (if_req && (!ls_req || (last_q == OWN_LS))) begin
        win_if_s = 1'b1;
      end else if (ls_req) begin
        win_ls_s = 1'b1;
      end else begin
        win_if_s = 1'b0;
        win_ls_s = 1'b0;
      end
    end else begin
      win_if_s = 1'b0;
      win_ls_s = 1'b0;
    end
  end

  assign if_gnt = win_if_s;
  assign ls_gnt = win_ls_s;

  // Response source: a real memory response wins over a coincident timeout.
  always_comb begin
    rsp_real_s  = 1'b0;
    rsp_to_s    = 1'b0;
    rsp_data_s  = '0;
    if (state_q == ST_WAIT) begin
      if (mem_rvalid) begin
        rsp_real_s = 1'b1;
        rsp_data_s = mem_rdata;
      end else if (WD_EN && (cnt_q == TO_LIMIT)) begin
        rsp_to_s   = 1'b1;
        rsp_data_s = TIMEOUT_DATA;
      end else begin
        rsp_real_s = 1'b0;
        rsp_to_s   = 1'b0;
      end
    end else begin
      rsp_real_s = 1'b0;
      rsp_to_s   = 1'b0;
    end
  end

  assign rsp_valid_s = rsp_real_s | rsp_to_s;

  // Route the response to the transaction owner; the other side sees zeros.
  always_comb begin
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    if (rsp_valid_s) begin
      if (owner_q == OWN_LS) begin
        ls_rvalid = 1'b1;
        ls_rdata  = rsp_data_s;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = rsp_data_s;
      end
    end else begin
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
    end
  end

  // Protocol violations and timeouts that latch the sticky error flag.
  always_comb begin
    err_set_s = 1'b0;
    if (rsp_to_s) begin
      err_set_s = 1'b1;
    end else if (mem_rvalid && (state_q != ST_WAIT)) begin
      err_set_s = 1'b1;
    end else if (mem_gnt && !mem_req_q) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Transaction FSM with registered memory-side payload, ownership and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_LS;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      if (err_set_s) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (win_if_s) begin
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            state_q     <= ST_REQ;
          end else if (win_ls_s) begin
            owner_q     <= OWN_LS;
            last_q      <= OWN_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we;
            mem_addr_q  <= ls_addr;
            mem_wdata_q <= ls_wdata;
            mem_wmask_q <= ls_wmask;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_valid_s) begin
            state_q <= ST_IDLE;
          end else if (WD_EN) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign err       = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DPI-backed memory port between instruction fetch (IF, read-only) and load/store (LS, read/write) for the multi-cycle core.
- Accepts one request at a time and arbitrates round-robin when both requesters are active.
- Registers the winner's payload, drives it to memory, and routes the response back to its owner.
- Includes a response watchdog so a hung memory cannot deadlock the core.

Parameters:
- AW, 32, address width
- DW, 32, data width (wmask width = DW/8)
- TIMEOUT, 255, maximum cycles in WAIT before a forced response; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch accepted, payload captured
- if_rvalid  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DW  fetch data
- ls_req  in  1  load/store request; held with its payload until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_wmask  in  DW/8  store byte enables
- ls_gnt  out  1  one-cycle pulse: LS accepted
- ls_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged
- ls_rdata  out  DW  load data
- mem_req  out  1  memory request (registered)
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  registered payload
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DW  memory response data
- err  out  1  sticky protocol/timeout error flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0; payload registers 0.
  - last_owner=LS, so IF wins the first tie.
  - Watchdog counter=0; err=0.
  - Reset mid-transaction abandons the transaction; no response is delivered to either requester.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Winner selection:
    - If exactly one req is high, that requester wins.
    - If both are high, the requester not equal to last_owner wins.
  - In the arbitration cycle, the winner's gnt pulses combinationally.
  - The winner's payload is captured into the mem_* registers, owner and last_owner are set to the winner, and the state goes to REQ.
  - An IF win forces mem_we=0 and mem_wmask=0.
- REQ:
  - mem_req=1; payload held stable.
  - On mem_gnt=1: mem_req drops the next cycle; state goes to WAIT; counter clears.
- WAIT:
  - On mem_rvalid=1: the owner's rvalid=1 this cycle; owner rdata=mem_rdata combinationally; state goes to IDLE.
  - The non-owner's rvalid stays 0 and its rdata is 0.
- Minimum turnaround:
  - req cycle 0, gnt cycle 0, mem_req cycle 1.
  - mem_gnt cycle 1, rvalid cycle 2.
  - Next arbitration cycle 3.
  - No new grant is issued in a cycle where rvalid is delivered.
- Watchdog (TIMEOUT>0):
  - The counter increments every WAIT cycle without mem_rvalid.
  - When the counter reaches TIMEOUT: owner rvalid pulses with rdata=32'hDEADBEEF, err is set, state goes to IDLE.
- err sets (sticky until reset) on:
  - watchdog timeout;
  - mem_rvalid in IDLE or REQ (the response is ignored);
  - mem_gnt while mem_req=0 (ignored).
- A requester dropping req before gnt is legal; it simply loses arbitration. Payload changes before gnt are sampled only in the arbitration cycle.
- Stores receive a response: ls_rvalid pulses with rdata equal to the mem_rdata value, which the LS unit must ignore.

Test Plan:
- Single fetch: if_req=1, if_addr=0x80000000; mem_gnt on the first REQ cycle; mem_rvalid the next cycle with 0x00100073 -> if_gnt at cycle 0, mem_addr=0x80000000 and mem_we=0 at cycle 1, if_rvalid=1 and if_rdata=0x00100073 at cycle 2, ls_rvalid=0 throughout.
- Tie: if_req and ls_req both held from reset -> grant order IF, LS, IF, LS; LS store with addr=0x80001000, wdata=0x12345678, wmask=0xF appears on the mem_* outputs exactly.
- Backpressure: mem_gnt held 0 for 5 cycles -> mem_req stays 1 with a stable payload for 5 cycles; a new ls_req in that window gets no ls_gnt until the current response returns.
- Timeout with TIMEOUT=4: mem_gnt given, mem_rvalid never asserted -> owner rvalid with rdata=0xDEADBEEF exactly 4 WAIT cycles later; err=1 and stays 1; the next request is served normally.
- Spurious response: mem_rvalid=1 while IDLE -> no rvalid to either requester; err=1.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> mem_req=0, err=0, state IDLE; the next tie goes to IF.
